// File: rtl/score_tracker.sv
// Score keeper for SnowFall: counts catches with a streak bonus and saturation,
// tracks lives through the IDLE/PLAY/OVER game flow and keeps a session high score.
module score_tracker #(
    parameter int unsigned MAX_SCORE  = 99,
    parameter int unsigned INIT_LIVES = 3,
    parameter int unsigned STREAK_LEN = 5
) (
    input  logic       CLK,
    input  logic       RST_BTN,
    input  logic       start,
    input  logic       catch_evt,
    input  logic       miss_evt,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [3:0] lives,
    output logic [1:0] game_state,
    output logic       score_upd
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t     state_reg;
    logic [3:0] streak_reg;

    logic [3:0] streak_inc;
    logic       bonus;
    logic [3:0] streak_after;
    logic [8:0] score_sum;
    logic [7:0] caught_score;
    logic [7:0] post_score;
    logic [7:0] best_score;

    // The sum is one bit wider than score so the bonus can never wrap past 255.
    assign streak_inc   = streak_reg + 4'd1;
    assign bonus        = (streak_inc == 4'(STREAK_LEN));
    assign streak_after = bonus ? 4'd0 : streak_inc;
    assign score_sum    = {1'b0, score} + (bonus ? 9'd2 : 9'd1);
    assign caught_score = (score_sum > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : score_sum[7:0];
    assign post_score   = catch_evt ? caught_score : score;
    assign best_score   = (post_score > high_score) ? post_score : high_score;

    assign game_state = state_reg;

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            state_reg  <= IDLE;
            score      <= 8'd0;
            high_score <= 8'd0;
            lives      <= 4'd0;
            streak_reg <= 4'd0;
            score_upd  <= 1'b0;
        end else begin
            score_upd <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (catch_evt) begin
                        score      <= caught_score;
                        streak_reg <= streak_after;
                        score_upd  <= (caught_score != score);
                    end
                    // A simultaneous miss still clears the streak after the catch is scored.
                    if (miss_evt) begin
                        streak_reg <= 4'd0;
                        lives      <= lives - 4'd1;
                        if (lives == 4'd1) begin
                            state_reg  <= OVER;
                            high_score <= best_score;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_reg  <= PLAY;
                        score      <= 8'd0;
                        lives      <= 4'(INIT_LIVES);
                        streak_reg <= 4'd0;
                        score_upd  <= (score != 8'd0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed game scenarios followed by random pulse traffic,
// every cycle compared against an arithmetic model of the game rules.
module tb_score_tracker;

    localparam int MAX_SCORE  = 99;
    localparam int INIT_LIVES = 3;
    localparam int STREAK_LEN = 5;

    logic       CLK = 1'b0;
    logic       RST_BTN;
    logic       start;
    logic       catch_evt;
    logic       miss_evt;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [3:0] lives;
    logic [1:0] game_state;
    logic       score_upd;

    int compares = 0;
    int fails    = 0;

    // Model state: 0 idle, 1 playing, 2 game over
    int m_state, m_score, m_high, m_lives, m_streak, m_upd;

    score_tracker #(
        .MAX_SCORE (MAX_SCORE),
        .INIT_LIVES(INIT_LIVES),
        .STREAK_LEN(STREAK_LEN)
    ) dut (
        .CLK       (CLK),
        .RST_BTN   (RST_BTN),
        .start     (start),
        .catch_evt (catch_evt),
        .miss_evt  (miss_evt),
        .score     (score),
        .high_score(high_score),
        .lives     (lives),
        .game_state(game_state),
        .score_upd (score_upd)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_lives = 0; m_streak = 0; m_upd = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit m);
        int old_score;
        old_score = m_score;
        if (m_state != 1) begin
            if (s) begin
                m_state  = 1;
                m_score  = 0;
                m_lives  = INIT_LIVES;
                m_streak = 0;
            end
        end else begin
            if (c) begin
                m_streak = m_streak + 1;
                if (m_streak == STREAK_LEN) begin
                    m_score  = m_score + 2;
                    m_streak = 0;
                end else begin
                    m_score = m_score + 1;
                end
                if (m_score > MAX_SCORE) m_score = MAX_SCORE;
            end
            if (m) begin
                m_streak = 0;
                m_lives  = m_lives - 1;
                if (m_lives == 0) begin
                    m_state = 2;
                    if (m_score > m_high) m_high = m_score;
                end
            end
        end
        m_upd = (m_score != old_score) ? 1 : 0;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".score"},      32'(score),      m_score);
        check({ctx, ".high_score"}, 32'(high_score), m_high);
        check({ctx, ".lives"},      32'(lives),      m_lives);
        check({ctx, ".game_state"}, 32'(game_state), m_state);
        check({ctx, ".score_upd"},  32'(score_upd),  m_upd);
    endtask

    // Drive one cycle of pulses, then sample 1 ns after the edge.
    task automatic step(input bit s, input bit c, input bit m);
        start = s; catch_evt = c; miss_evt = m;
        @(posedge CLK);
        #1;
        start = 1'b0; catch_evt = 1'b0; miss_evt = 1'b0;
        model_step(s, c, m);
        $display("cycle start=%0b catch=%0b miss=%0b -> score=%0d high=%0d lives=%0d state=%0d upd=%0b",
                 s, c, m, score, high_score, lives, game_state, score_upd);
        check_all("step");
    endtask

    initial begin
        RST_BTN = 1'b1; start = 1'b0; catch_evt = 1'b0; miss_evt = 1'b0;
        model_reset();
        #2 RST_BTN = 1'b0;
        #1;
        check_all("reset_async");
        @(negedge CLK);
        RST_BTN = 1'b1;

        // Events before a game are ignored
        step(0, 1, 0);
        step(0, 0, 1);

        // Start a game: score already 0 so no strobe
        step(1, 0, 0);
        check("t1.state", 32'(game_state), 1);
        check("t1.lives", 32'(lives), 3);
        check("t1.upd",   32'(score_upd), 0);

        // Five catches: 1,2,3,4,6
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            check("t2.upd", 32'(score_upd), 1);
        end
        check("t2.score", 32'(score), 6);

        // Build to 98 with streak 4, then saturate
        for (int i = 0; i < 74; i++) step(0, 1, 0);
        check("t3.score94", 32'(score), 94);
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        check("t3.score98", 32'(score), 98);
        step(0, 1, 0);
        check("t3.clip",     32'(score), 99);
        check("t3.clip_upd", 32'(score_upd), 1);
        step(0, 1, 0);
        check("t3.sat",     32'(score), 99);
        check("t3.sat_upd", 32'(score_upd), 0);

        // Start while playing is ignored
        step(1, 0, 0);

        // Lose the current game to record 99, then replay for score 7
        step(0, 0, 1);
        step(0, 0, 1);
        check("t4.high99", 32'(high_score), 99);
        step(1, 0, 0);
        check("t4.restart_upd", 32'(score_upd), 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        check("t4.score7", 32'(score), 7);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        check("t4.over",  32'(game_state), 2);
        check("t4.lives", 32'(lives), 0);
        check("t4.high",  32'(high_score), 99);
        step(0, 1, 0);
        check("t4.held", 32'(score), 7);
        step(1, 0, 0);
        check("t4.zero", 32'(score), 0);

        // Catch and miss together on streak 4
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(0, 1, 1);
        check("t5.score", 32'(score), 6);
        check("t5.lives", 32'(lives), 2);
        step(0, 1, 0);
        check("t5.next", 32'(score), 7);

        // Random traffic: a short-game phase and a long-game phase
        for (int i = 0; i < 1500; i++) begin
            bit s, c, m;
            int miss_pct;
            miss_pct = (i < 700) ? 8 : 1;
            s = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < 55);
            m = ($urandom_range(0, 99) < miss_pct);
            step(s, c, m);
        end

        // Reset between edges during a game
        if (m_state != 1) step(1, 0, 0);
        step(0, 1, 0);
        #2 RST_BTN = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        check("t6.score", 32'(score), 0);
        @(negedge CLK);
        RST_BTN = 1'b1;
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $fatal(1, "timeout");
    end

endmodule
